uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
REQ-002 Parameter SYS_CLK_FREQ, default 50000000, clk frequency in Hz.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit; integer, ≥ 4.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 rx_data  output  8  last correctly framed byte; held until the next good frame.
REQ-008 rx_valid  output  1  one-clk pulse: rx_data just updated.
REQ-009 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 Two-flop synchronizer on rx, both flops reset to 1; all logic uses the synchronized value rx_s.
REQ-012 Internal tick divisor DIV = SYS_CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer truncation, DIV ≥ 2.
- Tick counter counts 0..DIV-1 and wraps.
- Tick = counter at DIV-1.
- Counter held at 0 in IDLE and while leaving IDLE.
REQ-013 Sample counter s counts ticks 0..OVERSAMPLE-1 and wraps; cleared on every state change.
REQ-014 States: IDLE, START, DATA, STOP.
REQ-015 IDLE: falling edge of rx_s (previous 1, current 0) -> START.
- A level low without a preceding high never triggers a frame.
REQ-016 START: on the tick where s = OVERSAMPLE/2-1 (mid start bit):
- rx_s = 0 -> DATA, bit index 0.
- rx_s = 1 -> IDLE as a glitch; no output pulse.
REQ-017 DATA: on the tick where s = OVERSAMPLE-1, sample rx_s into shift register bit [index]; index increments 0..7.
- After index 7 -> STOP.
REQ-018 STOP: on the tick where s = OVERSAMPLE-1, sample rx_s, then go to IDLE.
- rx_s = 1: rx_data <= shift register; rx_valid = 1 for the next clk.
- rx_s = 0: frame_err = 1 for the next clk; rx_data unchanged.
REQ-019 rx_valid and frame_err are registered, mutually exclusive, and each high for exactly one clk per frame.
REQ-020 Latency:
- rx_valid/frame_err assert 1 clk after the STOP sample tick.
- That tick is ≈9.5 bit periods after the start falling edge at rx_s, plus 2 clk of synchronizer delay.
REQ-021 A new falling edge is accepted on the first clk back in IDLE, so back-to-back frames with one stop bit receive without loss.
REQ-022 rx edges during DATA/STOP are ignored except through the mid-bit sample; there is no resynchronization.
REQ-023 busy is combinational from state: 1 in START, DATA and STOP.

Reset
REQ-024 reset asserted, at any time including mid-frame:
- State to IDLE; tick counter, s, index and shift register to 0.
- rx_data to 8'h00; rx_valid, frame_err and busy to 0.
- Synchronizer flops to 1.
REQ-025 After reset release, the block needs a high-to-low transition on rx_s before any reception; a line already low at release is not a start bit.

Verification
Bench uses SYS_CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, so DIV=10 and a bit is 160 clk.
REQ-026 Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> single rx_valid pulse; rx_data = 8'hA5; frame_err stays 0; busy low after.
REQ-027 Drive frames 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses 1600 clk apart; rx_data 8'h00 then 8'hFF.
REQ-028 Low glitch of 40 clk on idle line -> busy pulses high, then returns to IDLE; no rx_valid or frame_err; rx_data unchanged.
REQ-029 After 0xA5, drive 0x3C with stop bit 0 -> one frame_err pulse, no rx_valid; rx_data stays 8'hA5.
- Then hold rx low for 3000 clk, then release high, then send 0x5A -> no further frame_err during the hold; rx_valid with 8'h5A.
REQ-030 Assert reset for 3 clk at mid-bit 4 of a frame -> all outputs 0 immediately.
- Remainder of that frame ignored until its bits end on an edge; a following clean 0x81 frame -> rx_data = 8'h81.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with oversampled mid-bit sampling.
// The raw line is synchronized, a falling edge in IDLE opens a frame, the
// start bit is confirmed at its midpoint, then each data bit and the stop bit
// are sampled one full bit period apart. A good frame updates rx_data and
// pulses rx_valid; a low stop bit pulses frame_err instead.
module uart_rx #(
  parameter int BAUD_RATE    = 9600,
  parameter int SYS_CLK_FREQ = 50000000,
  parameter int OVERSAMPLE   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic            rx_meta_reg, rx_s_reg;
  logic [1:0]      sync_ok_reg;
  logic            rx_prev_reg;
  logic [TW-1:0]   tick_cnt_reg;
  logic [SW-1:0]   s_reg;
  logic [2:0]      index_reg;
  logic [7:0]      shift_reg;
  logic            tick;
  logic            sample_bit;
  logic            stop_good;
  logic            stop_bad;

  // Two-flop synchronizer; rx_prev only takes values once rx_s reflects the
  // real line, so the forced-high reset value never fakes a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      sync_ok_reg <= 2'b00;
      rx_prev_reg <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      sync_ok_reg <= {sync_ok_reg[0], 1'b1};
      rx_prev_reg <= rx_s_reg & sync_ok_reg[1];
    end
  end

  assign tick = (tick_cnt_reg == TICK_LAST);

  // Next-state logic and per-tick sampling strobes.
  always_comb begin
    state_next = state_reg;
    sample_bit = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_prev_reg && !rx_s_reg) state_next = START;
      end
      START: begin
        if (tick && s_reg == S_MID) state_next = rx_s_reg ? IDLE : DATA;
      end
      DATA: begin
        if (tick && s_reg == S_LAST) begin
          sample_bit = 1'b1;
          if (index_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (tick && s_reg == S_LAST) begin
          state_next = IDLE;
          stop_good  = rx_s_reg;
          stop_bad   = !rx_s_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  // State register, tick divider, sample counter and bit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      s_reg        <= '0;
      index_reg    <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE || tick) tick_cnt_reg <= '0;
      else                           tick_cnt_reg <= tick_cnt_reg + TW'(1);
      if (state_next != state_reg)   s_reg <= '0;
      else if (tick)                 s_reg <= (s_reg == S_LAST) ? '0 : s_reg + SW'(1);
      if (state_reg == START)        index_reg <= 3'd0;
      else if (sample_bit)           index_reg <= index_reg + 3'd1;
    end
  end

  // Shift register: each bit captures the line at its own mid-bit sample.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   shift_reg[gi] <= 1'b0;
        else if (sample_bit && index_reg == 3'(gi))  shift_reg[gi] <= rx_s_reg;
      end
    end
  endgenerate

  // Registered result: data and one-cycle pulses issued from the stop sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= stop_good;
      frame_err <= stop_bad;
      if (stop_good) rx_data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames on rx and checks receiver outputs against
// a frame-level expectation model (queue of expected bytes, error counts).
module tb_uart_rx;

  localparam int BIT = 160;  // clk per bit: 1.6 MHz / 10 kbit/s

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .BAUD_RATE(10000),
    .SYS_CLK_FREQ(1600000),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt++;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: records pulses away from the active edge.
  logic [7:0] valid_q[$];
  int         vtime_q[$];
  int         ferr_cnt = 0;
  int         wide_cnt = 0;
  int         overlap_cnt = 0;
  bit         valid_prev = 0;
  bit         ferr_prev = 0;
  int         last_start = 0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_q.push_back(rx_data);
      vtime_q.push_back(cycle_cnt);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (rx_valid === 1'b1 && valid_prev) wide_cnt++;
    if (frame_err === 1'b1 && ferr_prev) wide_cnt++;
    if (rx_valid === 1'b1 && frame_err === 1'b1) overlap_cnt++;
    valid_prev = (rx_valid === 1'b1);
    ferr_prev  = (frame_err === 1'b1);
  end

  task automatic clear_mon();
    valid_q.delete();
    vtime_q.delete();
    ferr_cnt = 0;
    wide_cnt = 0;
    overlap_cnt = 0;
  endtask

  task automatic idle_line(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    last_start = cycle_cnt;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h, expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    reset = 1'b0;
    idle_line(50);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int lat;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    idle_line(100);
    last_good = 8'hA5;
    n_checks++; if (valid_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d pulses, expected 1", valid_q.size()); end
    if (valid_q.size() >= 1) begin
      n_checks++; if (valid_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h, expected a5", valid_q[0]); end
      // Stop sample lands 9.5 bits plus 2 sync clk after the line falls.
      lat = vtime_q[0] - last_start;
      n_checks++; if (lat < (BIT * 19) / 2 - 1 || lat > (BIT * 19) / 2 + 5) begin n_fail++; $display("FAIL single_latency: got %0d clk, expected about %0d", lat, (BIT * 19) / 2 + 2); end
    end
    n_checks++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d, expected 0", ferr_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, expected 0", busy); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_rx_data: got %h, expected a5", rx_data); end
    n_checks++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL single_pulse_width: got %0d wide pulses, expected 0", wide_cnt); end
    $display("test_single: rx_data=%h pulses=%0d", rx_data, valid_q.size());
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_line(100);
    last_good = 8'hFF;
    n_checks++; if (valid_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d pulses, expected 2", valid_q.size()); end
    if (valid_q.size() >= 2) begin
      n_checks++; if (valid_q[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h, expected 00", valid_q[0]); end
      n_checks++; if (valid_q[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h, expected ff", valid_q[1]); end
      n_checks++; if (vtime_q[1] - vtime_q[0] !== 10 * BIT) begin n_fail++; $display("FAIL b2b_spacing: got %0d clk, expected %0d", vtime_q[1] - vtime_q[0], 10 * BIT); end
    end
    n_checks++; if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_rx_data: got %h, expected ff", rx_data); end
    $display("test_back_to_back: pulses=%0d rx_data=%h", valid_q.size(), rx_data);
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b, expected 1", busy); end
    repeat (20) @(negedge clk);
    idle_line(200);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b, expected 0", busy); end
    n_checks++; if (valid_q.size() !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d pulses, expected 0", valid_q.size()); end
    n_checks++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d, expected 0", ferr_cnt); end
    n_checks++; if (rx_data !== last_good) begin n_fail++; $display("FAIL glitch_rx_data: got %h, expected %h", rx_data, last_good); end
    $display("test_glitch: rx_data=%h", rx_data);
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'hA5, 1'b1);
    idle_line(50);
    last_good = 8'hA5;
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL ferr_pre_data: got %h, expected a5", rx_data); end
    clear_mon();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (3000) @(negedge clk);
    n_checks++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d, expected 1", ferr_cnt); end
    n_checks++; if (valid_q.size() !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d pulses, expected 0", valid_q.size()); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL ferr_data_held: got %h, expected a5", rx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_hold_busy: got %b, expected 0", busy); end
    idle_line(100);
    send_frame(8'h5A, 1'b1);
    idle_line(100);
    last_good = 8'h5A;
    n_checks++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL ferr_after_hold: got %0d, expected 1", ferr_cnt); end
    n_checks++; if (valid_q.size() !== 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d pulses, expected 1", valid_q.size()); end
    n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL ferr_recover_data: got %h, expected 5a", rx_data); end
    n_checks++; if (overlap_cnt !== 0 || wide_cnt !== 0) begin n_fail++; $display("FAIL ferr_pulse_shape: got overlap=%0d wide=%0d, expected 0/0", overlap_cnt, wide_cnt); end
    $display("test_frame_err: ferr=%0d rx_data=%h", ferr_cnt, rx_data);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_ferr;
    logic [7:0] b;
    bit         good;
    int         gap;
    clear_mon();
    exp_ferr = 0;
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom_range(255, 0));
      good = ($urandom_range(3, 0) != 0);
      send_frame(b, good);
      if (good) begin
        exp_q.push_back(b);
        last_good = b;
      end else begin
        exp_ferr++;
      end
      // A bad stop leaves the line low; it must return high before the
      // next start bit can be seen as a falling edge.
      gap = good ? int'($urandom_range(200, 0)) : int'($urandom_range(200, 20));
      idle_line(gap);
      $display("random frame %0d: byte=%h stop=%0d gap=%0d", k, b, good, gap);
    end
    idle_line(200);
    n_checks++; if (valid_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d pulses, expected %0d", valid_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < valid_q.size(); i++) begin
      n_checks++; if (valid_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h, expected %h", i, valid_q[i], exp_q[i]); end
    end
    n_checks++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL rand_ferr: got %0d, expected %0d", ferr_cnt, exp_ferr); end
    n_checks++; if (rx_data !== last_good) begin n_fail++; $display("FAIL rand_rx_data: got %h, expected %h", rx_data, last_good); end
    n_checks++; if (overlap_cnt !== 0 || wide_cnt !== 0) begin n_fail++; $display("FAIL rand_pulse_shape: got overlap=%0d wide=%0d, expected 0/0", overlap_cnt, wide_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    // Frame 0x0F: bits 4..7 low, so the line stays low across the reset.
    last_start = cycle_cnt;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b1);
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %h, expected 00", rx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    n_checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: got valid=%b ferr=%b, expected 0/0", rx_valid, frame_err); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (BIT / 2 - 3) @(negedge clk);
    for (int i = 0; i < 3; i++) hold_bit(1'b0);
    hold_bit(1'b1);
    idle_line(100);
    last_good = 8'h00;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_tail_busy: got %b, expected 0", busy); end
    n_checks++; if (valid_q.size() !== 0 || ferr_cnt !== 0) begin n_fail++; $display("FAIL midrst_tail_pulses: got valid=%0d ferr=%0d, expected 0/0", valid_q.size(), ferr_cnt); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_tail_data: got %h, expected 00", rx_data); end
    clear_mon();
    send_frame(8'h81, 1'b1);
    idle_line(100);
    last_good = 8'h81;
    n_checks++; if (valid_q.size() !== 1) begin n_fail++; $display("FAIL midrst_next_count: got %0d pulses, expected 1", valid_q.size()); end
    n_checks++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL midrst_next_data: got %h, expected 81", rx_data); end
    $display("test_reset_mid_frame: rx_data=%h", rx_data);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
